// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit peripheral: register map, STATUS/CTRL bit positions, serializer states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  // Register offsets, selected by addr[3:2]
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // A divisor of zero would never end a bit; treat it as one cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular FIFO with power-of-two depth; pointers wrap naturally, count is one bit wider than the pointers.
// Latency: a pushed entry is visible on pop_dat_o the cycle after the push edge; pop_dat_o is combinational from rd_ptr.
// Backpressure: push ignored while full, pop ignored while empty; callers check full_o/empty_o.
// Ports: clk, resetn; push_i/push_dat_i write side; pop_i/pop_dat_o read side; full_o, empty_o, count_o status.
module uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so full is exactly the count MSB.
  assign full_o    = count_q[AW];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// UART transmitter peripheral: slave-bus register block, TX FIFO and 8N1 serializer with programmable divisor.
// Latency: bus response one cycle after acceptance; a byte written to an empty FIFO with the line idle starts its frame one edge later.
// Backpressure: none on the bus (gnt = req); a TXDATA write to a full FIFO is dropped and flagged in STATUS.overflow.
// Ports: clk, resetn; req/addr/we/be/wdata -> gnt/rvalid/rdata/err bus; tx serial line (idle high); irq level interrupt.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        gnt,
  output logic        rvalid,
  output logic        err,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- bus / register state ----------------
  logic        live_q;
  logic        accept;
  logic [1:0]  reg_sel;
  logic [15:0] div_q, div_d;
  logic        en_q, en_d, irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        irq_q, irq_d;
  logic [31:0] status_w;

  // ---------------- FIFO ----------------
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dat;
  logic [CW-1:0] fifo_count;

  // ---------------- serializer ----------------
  tx_state_e   state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [15:0] bdiv_q, bdiv_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic        tx_q, tx_d;
  logic        bit_end, start_ok;

  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16], be[3:2], fifo_count};

  assign gnt     = req;
  // Reset release is synchronous externally; the first edge after it is still not a transfer edge.
  assign accept  = req & live_q;
  assign reg_sel = addr[3:2];

  always_comb begin
    status_w            = '0;
    status_w[STAT_FULL] = fifo_full;
    status_w[STAT_EMPTY]= fifo_empty;
    status_w[STAT_BUSY] = (state_q != S_IDLE);
    status_w[STAT_OVF]  = ovf_q;
  end

  // Register decode. All read data reflects state before the accepting edge.
  always_comb begin
    rdata_d   = '0;
    err_d     = 1'b0;
    div_d     = div_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;
    fifo_push = 1'b0;
    if (accept) begin
      case (reg_sel)
        REG_STATUS: begin
          if (we) begin
            err_d = 1'b1;
          end else begin
            rdata_d = status_w;
            ovf_d   = 1'b0;
          end
        end
        REG_DIV: begin
          if (we) begin
            if (be[0]) div_d[7:0]  = wdata[7:0];
            if (be[1]) div_d[15:8] = wdata[15:8];
          end else begin
            rdata_d = {16'b0, div_q};
          end
        end
        REG_TXDATA: begin
          // Full is judged before the edge: a same-cycle pop does not make room.
          if (we && be[0]) begin
            if (fifo_full) ovf_d     = 1'b1;
            else           fifo_push = 1'b1;
          end
        end
        default: begin // REG_CTRL
          if (we) begin
            if (be[0]) begin
              en_d     = wdata[CTRL_EN];
              irq_en_d = wdata[CTRL_IRQ_EN];
            end
          end else begin
            rdata_d[CTRL_EN]     = en_q;
            rdata_d[CTRL_IRQ_EN] = irq_en_q;
          end
        end
      endcase
    end
  end

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (fifo_push),
    .push_dat_i (wdata[7:0]),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Serializer. Divisor is latched per frame so DIV writes only affect the next frame.
  assign bit_end  = (cyc_q == bdiv_q - 16'd1);
  assign start_ok = en_q & ~fifo_empty;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bdiv_d   = bdiv_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          fifo_pop = 1'b1;
          state_d  = S_START;
          byte_d   = fifo_dat;
          bdiv_d   = eff_div(div_q);
          cyc_d    = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: begin // S_STOP
        if (bit_end) begin
          cyc_d = '0;
          // Chain straight into the next frame when more data is waiting.
          if (start_ok) begin
            fifo_pop = 1'b1;
            state_d  = S_START;
            byte_d   = fifo_dat;
            bdiv_d   = eff_div(div_q);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
    endcase

    // Line level is registered from the next state so tx is glitch-free.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = byte_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign irq_d = irq_en_q & fifo_empty & (state_q == S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_q   <= 1'b0;
      div_q    <= DIV_RESET;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      bdiv_q   <= 16'd1;
      bit_q    <= '0;
      byte_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      live_q   <= 1'b1;
      div_q    <= div_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      rvalid_q <= accept;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bdiv_q   <= bdiv_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign tx     = tx_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph with a queue-based line/register model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_periph;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        gnt, rvalid, err, tx, irq;

  uart_tx_periph #(
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (16'd16)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .addr   (addr),
    .we     (we),
    .be     (be),
    .wdata  (wdata),
    .rdata  (rdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .err    (err),
    .tx     (tx),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The line is modelled as a queue of per-cycle levels for the frame in flight.
  logic [7:0]  m_fifo[$];
  logic        m_wave[$];
  logic [15:0] m_div;
  logic        m_en, m_irqen, m_ovf, m_live;
  logic        m_rvalid, m_err, m_irq;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_fifo.delete();
    m_wave.delete();
    m_div    = 16'd16;
    m_en     = 1'b0;
    m_irqen  = 1'b0;
    m_ovf    = 1'b0;
    m_live   = 1'b0;
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    m_irq    = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic model_step();
    logic        acc, wr, rd, pre_busy, v;
    logic [1:0]  a;
    logic [7:0]  b;
    logic [31:0] rv;
    int          pre_n, d;
    pre_n    = m_fifo.size();
    pre_busy = (m_wave.size() != 0);
    acc = req && m_live;
    a   = addr[3:2];
    wr  = acc && we;
    rd  = acc && !we;
    rv  = '0;
    if (rd) begin
      case (a)
        2'd0:    rv = {28'b0, m_ovf, pre_busy, (pre_n == 0), (pre_n == DEPTH)};
        2'd1:    rv = {16'b0, m_div};
        2'd3:    rv = {30'b0, m_irqen, m_en};
        default: rv = '0;
      endcase
    end
    m_irq = m_irqen && (pre_n == 0) && !pre_busy;
    // line: consume this cycle's level, then possibly launch the next frame
    if (m_wave.size() != 0) void'(m_wave.pop_front());
    if (m_wave.size() == 0 && m_en && pre_n != 0) begin
      b = m_fifo.pop_front();
      d = (m_div == 16'd0) ? 1 : int'(m_div);
      for (int k = 0; k < 10; k++) begin
        v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        for (int r = 0; r < d; r++) m_wave.push_back(v);
      end
    end
    if (rd && a == 2'd0) m_ovf = 1'b0;
    if (wr) begin
      case (a)
        2'd1: begin
          if (be[0]) m_div[7:0]  = wdata[7:0];
          if (be[1]) m_div[15:8] = wdata[15:8];
        end
        2'd2: if (be[0]) begin
          if (pre_n == DEPTH) m_ovf = 1'b1;
          else m_fifo.push_back(wdata[7:0]);
        end
        2'd3: if (be[0]) begin
          m_en    = wdata[0];
          m_irqen = wdata[1];
        end
        default: ;
      endcase
    end
    m_rvalid = acc;
    m_rdata  = rv;
    m_err    = wr && (a == 2'd0);
    m_live   = 1'b1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare, just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("gnt", 32'(gnt), 32'(req));
      chk("tx", 32'(tx), 32'((m_wave.size() != 0) ? m_wave[0] : 1'b1));
      chk("rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("rdata", rdata, m_rdata);
      chk("err", 32'(err), 32'(m_err));
      chk("irq", 32'(irq), 32'(m_irq));
    end
  end

  // ---------------- bus tasks (called at a negedge, return at the next) ----------------
  task automatic bus(input logic w, input logic [1:0] a, input logic [3:0] b, input logic [31:0] d,
                     output logic [31:0] rd, output logic e);
    req   = 1'b1;
    we    = w;
    addr  = {28'h9a10000, a, 2'b00};
    be    = b;
    wdata = d;
    @(negedge clk);
    req = 1'b0;
    we  = 1'b0;
    rd  = rdata;
    e   = err;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d, output logic e);
    logic [31:0] unused_rd;
    bus(1'b1, a, b, d, unused_rd, e);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] rd);
    logic unused_e;
    bus(1'b0, a, 4'hF, 32'h0, rd, unused_e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] r;
    logic        e;
    logic [9:0]  pat;
    logic [19:0] frames;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 0x55 at DIV=4
    bus_wr(2'd1, 4'b0011, 32'd4, e);
    bus_wr(2'd3, 4'b0001, 32'd1, e);
    bus_wr(2'd2, 4'b0001, 32'h55, e);
    chk("A_tx_before_start", 32'(tx), 32'd1);
    pat = 10'b1010101010;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("A_tx_bit", 32'(tx), 32'(pat[i/4]));
    end
    bus_rd(2'd0, r);
    chk("A_status_last_stop", r, 32'h6);
    bus_rd(2'd0, r);
    chk("A_status_idle", r, 32'h2);

    // overflow with enable off
    bus_wr(2'd3, 4'b0001, 32'd0, e);
    for (int i = 0; i < 9; i++) begin
      bus_wr(2'd2, 4'b0001, 32'h10 + 32'(i), e);
      chk("B_wr_err", 32'(e), 32'd0);
    end
    bus_rd(2'd0, r);
    chk("B_status_ovf", r, 32'h9);
    bus_rd(2'd0, r);
    chk("B_status_cleared", r, 32'h1);
    bus_wr(2'd1, 4'b0011, 32'd1, e);
    bus_wr(2'd3, 4'b0001, 32'd1, e);
    repeat (90) @(negedge clk);
    bus_rd(2'd0, r);
    chk("B_drained", r, 32'h2);

    // back-to-back frames at DIV=2 with irq
    bus_wr(2'd1, 4'b0011, 32'd2, e);
    bus_wr(2'd3, 4'b0001, 32'd3, e);
    bus_wr(2'd2, 4'b0001, 32'h41, e);
    bus_wr(2'd2, 4'b0001, 32'h42, e);
    frames = {10'b1010000100, 10'b1010000010};
    for (int i = 0; i < 40; i++) begin
      chk("C_tx_bit", 32'(tx), 32'(frames[i/2]));
      @(negedge clk);
    end
    chk("C_tx_idle", 32'(tx), 32'd1);
    chk("C_irq_low", 32'(irq), 32'd0);
    @(negedge clk);
    chk("C_irq_high", 32'(irq), 32'd1);

    // write to STATUS
    bus_wr(2'd0, 4'hF, 32'hFFFF_FFFF, e);
    chk("D_status_wr_err", 32'(e), 32'd1);
    bus_rd(2'd0, r);
    chk("D_status_unchanged", r, 32'h2);

    // DIV=0 frame, DIV=8 written mid-frame
    bus_wr(2'd1, 4'b0011, 32'd0, e);
    bus_wr(2'd2, 4'b0001, 32'hA5, e);
    pat = 10'b1101001010;
    @(negedge clk);
    chk("E_tx_bit", 32'(tx), 32'(pat[0]));
    bus_wr(2'd1, 4'b0011, 32'd8, e);
    for (int i = 1; i < 10; i++) begin
      chk("E_tx_bit", 32'(tx), 32'(pat[i]));
      @(negedge clk);
    end
    chk("E_tx_idle", 32'(tx), 32'd1);
    bus_rd(2'd0, r);
    chk("E_status_idle", r, 32'h2);
    bus_rd(2'd1, r);
    chk("E_div_new", r, 32'd8);

    // reset in the middle of a data bit
    bus_wr(2'd1, 4'b0011, 32'd4, e);
    bus_wr(2'd2, 4'b0001, 32'h00, e);
    bus_wr(2'd2, 4'b0001, 32'hFF, e);
    repeat (6) @(negedge clk);
    chk("F_tx_data_bit", 32'(tx), 32'd0);
    resetn = 1'b0;
    #1;
    chk("F_tx_async_high", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    bus_rd(2'd0, r);
    chk("F_status_after_rst", r, 32'h2);
    bus_rd(2'd1, r);
    chk("F_div_after_rst", r, 32'd16);
    bus_rd(2'd3, r);
    chk("F_ctrl_after_rst", r, 32'd0);

    // byte enables and TXDATA corner cases
    bus_wr(2'd1, 4'b0011, 32'h1234, e);
    bus_wr(2'd1, 4'b0010, 32'hABCD, e);
    bus_rd(2'd1, r);
    chk("G_div_bytewise", r, 32'hAB34);
    bus_wr(2'd2, 4'b0010, 32'h77, e);
    chk("G_txdata_nobe_err", 32'(e), 32'd0);
    bus_rd(2'd0, r);
    chk("G_status_no_push", r, 32'h2);
    bus_rd(2'd2, r);
    chk("G_txdata_read", r, 32'd0);
    bus_wr(2'd3, 4'b1110, 32'h3, e);
    bus_rd(2'd3, r);
    chk("G_ctrl_be_masked", r, 32'd0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DIV_RESET, default 16'd16, meaning the reset value of the baud divisor.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  1  slave-bus request, pre-decoded for the 0x9a10_000x window.
REQ-006 SHALL have port addr  input  32  byte address; only addr[3:2] is decoded.
REQ-007 SHALL have ports we  input  1  write enable; be  input  4  byte enables; wdata  input  32  write data.
REQ-008 SHALL have ports rdata  output  32  read data; gnt  output  1  grant; rvalid  output  1  response valid; err  output  1  response error.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port irq  output  1  level interrupt.

Function
REQ-011 SHALL drive gnt = req combinationally; a transfer is accepted on any edge where req is high.
REQ-012 SHALL assert rvalid for exactly one cycle, in the cycle after acceptance; rdata and err are valid only while rvalid is high, and are 0 otherwise.
REQ-013 SHALL decode addr[3:2] as: 0 STATUS (read-only), 1 DIV (rw, bits 15:0), 2 TXDATA (write-only), 3 CTRL (rw, bit0 enable, bit1 irq_en).
REQ-014 SHALL define STATUS as: bit0 fifo_full, bit1 fifo_empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits 31:4 zero.
REQ-015 SHALL clear overflow on an accepted STATUS read; a new overflow event in the same cycle takes priority and keeps the bit set.
REQ-016 SHALL respond with err=1 to a write to STATUS; the write has no effect.
REQ-017 SHALL return rdata=0 and err=0 for a read of TXDATA.
REQ-018 SHALL push wdata[7:0] into the FIFO on an accepted TXDATA write with be[0]=1; when be[0]=0, the write is a no-op with err=0.
REQ-019 SHALL drop a TXDATA write when the FIFO is full before the edge, even if a pop occurs in the same cycle; the drop sets overflow and gives err=0.
REQ-020 SHALL apply DIV and CTRL writes per byte enable.
REQ-021 SHALL run a serializer FSM with states IDLE, START, DATA, STOP.
REQ-022 SHALL pop the FIFO and go IDLE->START on an edge where enable=1 and the FIFO is non-empty; the same edge latches the byte and the effective divisor (DIV, with 0 treated as 1).
REQ-023 SHALL hold each bit for exactly the latched-divisor number of cycles; tx=0 in START, tx=data bit in DATA (LSB first, 8 bits, 3-bit counter), tx=1 in STOP and IDLE.
REQ-024 SHALL go STOP->START directly when STOP ends, enable=1 and the FIFO is non-empty (back-to-back frames, no idle gap); otherwise STOP->IDLE.
REQ-025 SHALL make a complete frame last 10*div cycles.
REQ-026 SHALL let a DIV write during a frame affect only the next frame.
REQ-027 SHALL let enable=0 during a frame finish that frame, then stay in IDLE with the FIFO retained.
REQ-028 SHALL start a frame on the edge after an accepted TXDATA write to an empty FIFO with idle FSM and enable=1, so that tx falls in the cycle after that edge.
REQ-029 SHALL drive irq = irq_en & fifo_empty & (state==IDLE), registered.
REQ-030 SHALL use a circular FIFO whose pointers wrap modulo FIFO_DEPTH, with a count of width log2(FIFO_DEPTH)+1.

Reset
REQ-031 SHALL, on resetn low, asynchronously force: FSM=IDLE, tx=1, FIFO empty, overflow=0, DIV=DIV_RESET, CTRL=0, rvalid=0, err=0, rdata=0, irq=0.
REQ-032 SHALL abort any frame in progress on reset mid-frame and hold tx high.
REQ-033 SHALL accept no transfer in the first edge after deassertion; deassertion is synchronized externally.

Structure
REQ-034 SHALL place the register offsets, STATUS bit positions and the FSM state enum in package uart_pkg.
REQ-035 SHALL implement the FIFO as sub-module uart_fifo (push/pop/full/empty/count, parameter DEPTH, WIDTH=8).

Verification
REQ-036 SHALL cover: DIV=4, enable=1, write 0x55 to TXDATA -> start bit low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles, busy back to 0 after 40 cycles.
REQ-037 SHALL cover: write 9 bytes back-to-back with enable=0 -> first 8 give err=0 and fifo_full=1; the 9th is dropped with overflow=1; a STATUS read returns 0x9; the next read returns 0x1.
REQ-038 SHALL cover: enable=1, DIV=2, write 0x41 and 0x42 -> two frames with no idle cycle between them, 40 cycles total; irq high one cycle after the last STOP when irq_en=1.
REQ-039 SHALL cover: write to STATUS -> rvalid with err=1 one cycle later; STATUS is unchanged.
REQ-040 SHALL cover: resetn low in the middle of a DATA bit -> tx=1 immediately, STATUS reads 0x2 after release, DIV reads 16.
REQ-041 SHALL cover: DIV=0 -> 1-cycle bits (10-cycle frame); a DIV write to 8 mid-frame leaves the current frame at 1 cycle per bit.
